// File: rtl/vga_frame_scanner_pkg.sv
// Shared 640x480@60 timing constants and the column-major frame-buffer address helper.
// Also used by the blur stage, so the address mapping has a single definition.
package vga_pkg;

  localparam int FB_WIDTH   = 160;
  localparam int FB_HEIGHT  = 120;
  localparam int SCALE      = 4;
  localparam int SCALE_LOG2 = $clog2(SCALE);
  localparam int CLK_DIV    = 4;
  localparam int ADDR_W     = 15;
  localparam int X_W        = 8;
  localparam int Y_W        = 7;
  localparam int CNT_W      = 10;

  typedef logic [CNT_W-1:0]  cnt_t;
  typedef logic [ADDR_W-1:0] addr_t;

  localparam cnt_t H_ACTIVE = 10'd640;
  localparam cnt_t H_FP     = 10'd16;
  localparam cnt_t H_SYNC   = 10'd96;
  localparam cnt_t H_BP     = 10'd48;
  localparam cnt_t H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;

  localparam cnt_t V_ACTIVE = 10'd480;
  localparam cnt_t V_FP     = 10'd10;
  localparam cnt_t V_SYNC   = 10'd2;
  localparam cnt_t V_BP     = 10'd33;
  localparam cnt_t V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;

  typedef struct packed {
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } rgb_t;

  // Column-major: one stored column occupies FB_HEIGHT consecutive words.
  function automatic addr_t fb_addr(input logic [X_W-1:0] x, input logic [Y_W-1:0] y);
    return addr_t'(x) * addr_t'(FB_HEIGHT) + addr_t'(y);
  endfunction

  function automatic rgb_t to_rgb(input logic [23:0] pix);
    return '{r: pix[23:20], g: pix[15:12], b: pix[7:4]};
  endfunction

endpackage

// File: rtl/vga_frame_scanner_if.sv
// Frame-buffer read port plus VGA pin bundle between the scanner and its surroundings.
interface vga_frame_scanner_if;
  import vga_pkg::*;

  logic        display_enable;
  logic [23:0] pixel_data;
  addr_t       display_address;
  logic [3:0]  vga_r;
  logic [3:0]  vga_g;
  logic [3:0]  vga_b;
  logic        vga_hsync;
  logic        vga_vsync;
  logic        active_video;
  logic        frame_start;

  modport master (
    input  display_enable, pixel_data,
    output display_address, vga_r, vga_g, vga_b,
           vga_hsync, vga_vsync, active_video, frame_start
  );

  modport slave (
    output display_enable, pixel_data,
    input  display_address, vga_r, vga_g, vga_b,
           vga_hsync, vga_vsync, active_video, frame_start
  );

endinterface

// File: rtl/vga_frame_scanner_timing_gen.sv
// Pixel-tick divider and 800x525 raster counters with raw (unregistered) visible/sync flags.
module vga_timing_gen
  import vga_pkg::*;
(
  input  logic clk,
  input  logic rst,
  output logic o_tick,
  output cnt_t o_hcnt,
  output cnt_t o_vcnt,
  output logic o_visible,
  output logic o_hsync_n,
  output logic o_vsync_n
);

  localparam int DIV_W = $clog2(CLK_DIV);
  localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0] r_div_cnt;
  cnt_t             r_hcnt;
  cnt_t             r_vcnt;
  logic             w_tick;

  assign w_tick = (r_div_cnt == DIV_MAX);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_div_cnt <= '0;
      r_hcnt    <= '0;
      r_vcnt    <= '0;
    end else begin
      r_div_cnt <= w_tick ? '0 : r_div_cnt + 1'b1;
      if (w_tick) begin
        if (r_hcnt == H_TOTAL - 1'b1) begin
          r_hcnt <= '0;
          r_vcnt <= (r_vcnt == V_TOTAL - 1'b1) ? '0 : r_vcnt + 1'b1;
        end else begin
          r_hcnt <= r_hcnt + 1'b1;
        end
      end
    end
  end

  assign o_tick    = w_tick;
  assign o_hcnt    = r_hcnt;
  assign o_vcnt    = r_vcnt;
  assign o_visible = (r_hcnt < H_ACTIVE) && (r_vcnt < V_ACTIVE);
  assign o_hsync_n = !((r_hcnt >= H_ACTIVE + H_FP) && (r_hcnt < H_ACTIVE + H_FP + H_SYNC));
  assign o_vsync_n = !((r_vcnt >= V_ACTIVE + V_FP) && (r_vcnt < V_ACTIVE + V_FP + V_SYNC));

endmodule

// File: rtl/vga_frame_scanner.sv
// Scans the 160x120 frame buffer at 4x4 replication onto 640x480@60 VGA with a
// two-tick pipeline: address/flags in stage 1, RGB/syncs registered in stage 2.
module vga_frame_scanner
  import vga_pkg::*;
(
  input  logic                       clk,
  input  logic                       rst,
  vga_frame_scanner_if.master        io_vga
);

  logic           w_tick;
  logic           w_visible;
  logic           w_hsync_n;
  logic           w_vsync_n;
  cnt_t           w_hcnt;
  cnt_t           w_vcnt;
  logic [X_W-1:0] w_x;
  logic [Y_W-1:0] w_y;
  rgb_t           w_pix_rgb;

  addr_t r_addr;
  logic  r_act1;
  logic  r_hs1;
  logic  r_vs1;
  rgb_t  r_rgb;
  logic  r_active;
  logic  r_hsync;
  logic  r_vsync;
  logic  r_frame_start;

  vga_timing_gen u_timing (
    .clk       (clk),
    .rst       (rst),
    .o_tick    (w_tick),
    .o_hcnt    (w_hcnt),
    .o_vcnt    (w_vcnt),
    .o_visible (w_visible),
    .o_hsync_n (w_hsync_n),
    .o_vsync_n (w_vsync_n)
  );

  assign w_x       = X_W'(w_hcnt >> SCALE_LOG2);
  assign w_y       = Y_W'(w_vcnt >> SCALE_LOG2);
  assign w_pix_rgb = to_rgb(io_vga.pixel_data);

  // Stage-1 sync flags reset to their inactive level so the pins never glitch low.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_addr        <= '0;
      r_act1        <= 1'b0;
      r_hs1         <= 1'b1;
      r_vs1         <= 1'b1;
      r_rgb         <= '0;
      r_active      <= 1'b0;
      r_hsync       <= 1'b1;
      r_vsync       <= 1'b1;
      r_frame_start <= 1'b0;
    end else begin
      r_frame_start <= w_tick && (w_hcnt == '0) && (w_vcnt == '0);
      if (w_tick) begin
        if (w_visible) begin
          r_addr <= fb_addr(w_x, w_y);
        end
        r_act1   <= w_visible;
        r_hs1    <= w_hsync_n;
        r_vs1    <= w_vsync_n;
        // pixel_data has settled for r_addr by now; blanking must drive the DAC to zero.
        r_rgb    <= (r_act1 && io_vga.display_enable) ? w_pix_rgb : '0;
        r_active <= r_act1;
        r_hsync  <= r_hs1;
        r_vsync  <= r_vs1;
      end
    end
  end

  assign io_vga.display_address = r_addr;
  assign io_vga.vga_r           = r_rgb.r;
  assign io_vga.vga_g           = r_rgb.g;
  assign io_vga.vga_b           = r_rgb.b;
  assign io_vga.vga_hsync       = r_hsync;
  assign io_vga.vga_vsync       = r_vsync;
  assign io_vga.active_video    = r_active;
  assign io_vga.frame_start     = r_frame_start;

endmodule

// File: tb/tb_vga_frame_scanner.sv
// Directed bench for vga_frame_scanner: tick k after reset release lands on clk 4*(k+1)
// and scans hcnt=k%800, vcnt=k/800; stage-2 pins for tick k appear after tick k+1.
module tb_vga_frame_scanner;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic echo = 1'b0;
  int   clk_cnt = 0;
  int   checks = 0;
  int   errors = 0;

  vga_frame_scanner_if bus ();

  vga_frame_scanner dut (
    .clk    (clk),
    .rst    (rst),
    .io_vga (bus)
  );

  always #5 clk = ~clk;

  // Registered-read frame buffer model: constant colour or an echo of the address.
  always @(posedge clk) begin
    bus.pixel_data <= echo ? {bus.display_address, 9'd0} : 24'hA5C3F0;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic run_to_clk(input int target);
    while (clk_cnt < target) begin
      @(posedge clk);
      clk_cnt++;
    end
    #1;
  endtask

  task automatic run_to_tick(input int k);
    run_to_clk(4 * (k + 1));
  endtask

  function automatic logic [31:0] rgb();
    return {20'd0, bus.vga_r, bus.vga_g, bus.vga_b};
  endfunction

  task automatic check_reset_state(input string tag);
    $display("%s: reset state", tag);
    check({tag, "_hsync"}, 32'(bus.vga_hsync), 32'd1);
    check({tag, "_vsync"}, 32'(bus.vga_vsync), 32'd1);
    check({tag, "_rgb"}, rgb(), 32'h0);
    check({tag, "_active"}, 32'(bus.active_video), 32'd0);
    check({tag, "_fs"}, 32'(bus.frame_start), 32'd0);
    check({tag, "_addr"}, 32'(bus.display_address), 32'd0);
  endtask

  int hs_low;
  int act_hi;
  int vs_low;

  initial begin
    bus.display_enable = 1'b1;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_reset_state("rst0");
    rst = 1'b0;
    clk_cnt = 0;

    run_to_clk(3);
    $display("clk3 after release: no tick yet");
    check("fs_clk3", 32'(bus.frame_start), 32'd0);
    run_to_tick(0);
    $display("tick0: frame_start");
    check("fs_tick0", 32'(bus.frame_start), 32'd1);
    check("addr_t0", 32'(bus.display_address), 32'd0);
    check("active_t0", 32'(bus.active_video), 32'd0);
    check("hsync_t0", 32'(bus.vga_hsync), 32'd1);
    run_to_clk(5);
    check("fs_clk5", 32'(bus.frame_start), 32'd0);
    run_to_tick(1);
    $display("tick1: first visible pixel on pins");
    check("active_t1", 32'(bus.active_video), 32'd1);
    check("rgb_t1", rgb(), 32'hACF);

    run_to_tick(3);  check("addr_h3", 32'(bus.display_address), 32'd0);
    run_to_tick(4);  check("addr_h4", 32'(bus.display_address), 32'd120);
    run_to_tick(7);  check("addr_h7", 32'(bus.display_address), 32'd120);
    run_to_tick(8);  check("addr_h8", 32'(bus.display_address), 32'd240);
    run_to_tick(639); check("addr_h639", 32'(bus.display_address), 32'd19080);
    run_to_tick(640);
    $display("tick640: address hold, last visible pixel on pins");
    check("addr_hold", 32'(bus.display_address), 32'd19080);
    check("rgb_h639", rgb(), 32'hACF);
    check("active_h639", 32'(bus.active_video), 32'd1);
    run_to_tick(641);
    check("rgb_h640", rgb(), 32'h0);
    check("active_h640", 32'(bus.active_video), 32'd0);
    run_to_tick(656); check("hsync_h655", 32'(bus.vga_hsync), 32'd1);
    run_to_tick(657); check("hsync_h656", 32'(bus.vga_hsync), 32'd0);
    run_to_tick(700); check("rgb_blank", rgb(), 32'h0);
    run_to_tick(752); check("hsync_h751", 32'(bus.vga_hsync), 32'd0);
    run_to_tick(753); check("hsync_h752", 32'(bus.vga_hsync), 32'd1);
    run_to_tick(800);
    $display("tick800: start of line 1");
    check("addr_v1", 32'(bus.display_address), 32'd0);
    check("fs_v1", 32'(bus.frame_start), 32'd0);

    hs_low = 0; act_hi = 0; vs_low = 0;
    for (int k = 801; k <= 1600; k++) begin
      run_to_tick(k);
      if (!bus.vga_hsync) hs_low++;
      if (bus.active_video) act_hi++;
      if (!bus.vga_vsync) vs_low++;
    end
    $display("line1: hsync_low=%0d active=%0d vsync_low=%0d", hs_low, act_hi, vs_low);
    check("line_hs_low", 32'(hs_low), 32'd96);
    check("line_active", 32'(act_hi), 32'd640);
    check("line_vs_low", 32'(vs_low), 32'd0);

    run_to_tick(1604); check("addr_v2h4", 32'(bus.display_address), 32'd120);
    run_to_tick(3200); check("addr_v4h0", 32'(bus.display_address), 32'd1);
    echo = 1'b1;
    run_to_tick(3204); check("addr_v4h4", 32'(bus.display_address), 32'd121);
    run_to_tick(3205);
    $display("tick3205: echoed pixel of address 121");
    check("rgb_echo121", rgb(), 32'h0F0);
    run_to_tick(3839); check("addr_v4h639", 32'(bus.display_address), 32'd19081);
    run_to_tick(3840);
    $display("tick3840: echoed pixel of address 19081");
    check("rgb_echo19081", rgb(), 32'h910);
    echo = 1'b0;

    run_to_tick(4100); check("rgb_en_on", rgb(), 32'hACF);
    bus.display_enable = 1'b0;
    run_to_tick(4101);
    $display("tick4101: display disabled");
    check("rgb_en_off", rgb(), 32'h0);
    check("active_en_off", 32'(bus.active_video), 32'd1);
    check("hsync_en_off", 32'(bus.vga_hsync), 32'd1);
    run_to_tick(4657);
    check("hsync_dis_sync", 32'(bus.vga_hsync), 32'd0);
    check("rgb_dis_sync", rgb(), 32'h0);
    bus.display_enable = 1'b1;
    run_to_tick(4802); check("rgb_re_en", rgb(), 32'hACF);

    run_to_tick(5100);
    check("rgb_pre_rst", rgb(), 32'hACF);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check_reset_state("rst_mid");
    rst = 1'b0;
    clk_cnt = 0;
    run_to_clk(3);
    check("fs2_clk3", 32'(bus.frame_start), 32'd0);
    run_to_tick(0);
    $display("restart tick0: frame_start");
    check("fs2_tick0", 32'(bus.frame_start), 32'd1);
    run_to_tick(4);
    check("addr2_h4", 32'(bus.display_address), 32'd120);
    check("vsync2", 32'(bus.vga_vsync), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
